// File: rtl/lsu_dccm_wrbuf.sv
// Store write buffer ahead of the DCCM write port: in-order drain on idle read cycles plus RAW hazard detection.
// Optional store-to-load forwarding is enabled with `define RV_DCCM_WRBUF_FWD_EN.

module lsu_dccm_wrbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 39
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lsu_freeze_dc3,
  input  logic          enq_valid,
  output logic          enq_ready,
  input  logic [AW-1:0] enq_addr,
  input  logic [DW-1:0] enq_data,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr_lo,
  input  logic [AW-1:0] rd_addr_hi,
  output logic          rd_conflict,
  output logic          fwd_hit_lo,
  output logic          fwd_hit_hi,
  output logic [DW-1:0] fwd_data_lo,
  output logic [DW-1:0] fwd_data_hi,
  output logic          dccm_wren,
  output logic [AW-1:0] dccm_wr_addr,
  output logic [DW-1:0] dccm_wr_data,
  output logic          wrbuf_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [PW:0]      r_count;
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic             w_drain;
  logic [DEPTH-1:0] w_hitLo;
  logic [DEPTH-1:0] w_hitHi;
  logic             w_enqMatchLo;
  logic             w_enqMatchHi;
  logic             w_unused;

  assign w_full   = (r_count == (PW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_enq    = enq_valid & ~w_full;
  assign w_drain  = ~w_empty & ~rd_req & ~lsu_freeze_dc3;
  assign w_unused = ^{rd_addr_lo[1:0], rd_addr_hi[1:0]};

  assign enq_ready    = ~w_full;
  assign wrbuf_empty  = w_empty;
  assign dccm_wren    = w_drain;
  assign dccm_wr_addr = r_valid[r_rdPtr] ? r_addr[r_rdPtr] : '0;
  assign dccm_wr_data = r_valid[r_rdPtr] ? r_data[r_rdPtr] : '0;

  // Word-granular match: byte offset bits never distinguish DCCM words.
  always_comb begin
    w_hitLo = '0;
    w_hitHi = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_hitLo[i] = r_valid[i] & (r_addr[i][AW-1:2] == rd_addr_lo[AW-1:2]);
      w_hitHi[i] = r_valid[i] & (r_addr[i][AW-1:2] == rd_addr_hi[AW-1:2]);
    end
  end

  assign w_enqMatchLo = w_enq & (enq_addr[AW-1:2] == rd_addr_lo[AW-1:2]);
  assign w_enqMatchHi = w_enq & (enq_addr[AW-1:2] == rd_addr_hi[AW-1:2]);

`ifdef RV_DCCM_WRBUF_FWD_EN
  logic          w_youngHitLo;
  logic          w_youngHitHi;
  logic [DW-1:0] w_youngDataLo;
  logic [DW-1:0] w_youngDataHi;

  // Walk from the newest entry backwards so the youngest matching store wins.
  always_comb begin
    logic [PW-1:0] idx;
    w_youngHitLo  = 1'b0;
    w_youngHitHi  = 1'b0;
    w_youngDataLo = '0;
    w_youngDataHi = '0;
    idx           = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = r_wrPtr - PW'(k + 1);
      if (!w_youngHitLo && w_hitLo[idx]) begin
        w_youngHitLo  = 1'b1;
        w_youngDataLo = r_data[idx];
      end
      if (!w_youngHitHi && w_hitHi[idx]) begin
        w_youngHitHi  = 1'b1;
        w_youngDataHi = r_data[idx];
      end
    end
  end

  assign fwd_hit_lo  = rd_req & w_youngHitLo;
  assign fwd_hit_hi  = rd_req & w_youngHitHi;
  assign fwd_data_lo = fwd_hit_lo ? w_youngDataLo : '0;
  assign fwd_data_hi = fwd_hit_hi ? w_youngDataHi : '0;
  assign rd_conflict = rd_req & (w_enqMatchLo | w_enqMatchHi);
`else
  assign fwd_hit_lo  = 1'b0;
  assign fwd_hit_hi  = 1'b0;
  assign fwd_data_lo = '0;
  assign fwd_data_hi = '0;
  assign rd_conflict = rd_req & ((|w_hitLo) | (|w_hitHi) | w_enqMatchLo | w_enqMatchHi);
`endif

  // Pointer, occupancy and valid bookkeeping; reset discards every pending store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_enq) begin
        r_wrPtr          <= r_wrPtr + 1'b1;
        r_valid[r_wrPtr] <= 1'b1;
      end
      if (w_drain) begin
        r_rdPtr          <= r_rdPtr + 1'b1;
        r_valid[r_rdPtr] <= 1'b0;
      end
      case ({w_enq, w_drain})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wrPtr] <= enq_addr;
      r_data[r_wrPtr] <= enq_data;
    end
  end

endmodule

// File: tb/tb_lsu_dccm_wrbuf.sv
// Directed self-checking bench for lsu_dccm_wrbuf; expectations follow RV_DCCM_WRBUF_FWD_EN when defined.

module tb_lsu_dccm_wrbuf;

  localparam int AW = 16;
  localparam int DW = 39;

  logic          clk = 1'b0;
  logic          rst;
  logic          lsu_freeze_dc3;
  logic          enq_valid;
  logic          enq_ready;
  logic [AW-1:0] enq_addr;
  logic [DW-1:0] enq_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr_lo;
  logic [AW-1:0] rd_addr_hi;
  logic          rd_conflict;
  logic          fwd_hit_lo;
  logic          fwd_hit_hi;
  logic [DW-1:0] fwd_data_lo;
  logic [DW-1:0] fwd_data_hi;
  logic          dccm_wren;
  logic [AW-1:0] dccm_wr_addr;
  logic [DW-1:0] dccm_wr_data;
  logic          wrbuf_empty;

  int compared   = 0;
  int mismatched = 0;

  lsu_dccm_wrbuf #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .lsu_freeze_dc3 (lsu_freeze_dc3),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_addr       (enq_addr),
    .enq_data       (enq_data),
    .rd_req         (rd_req),
    .rd_addr_lo     (rd_addr_lo),
    .rd_addr_hi     (rd_addr_hi),
    .rd_conflict    (rd_conflict),
    .fwd_hit_lo     (fwd_hit_lo),
    .fwd_hit_hi     (fwd_hit_hi),
    .fwd_data_lo    (fwd_data_lo),
    .fwd_data_hi    (fwd_data_hi),
    .dccm_wren      (dccm_wren),
    .dccm_wr_addr   (dccm_wr_addr),
    .dccm_wr_data   (dccm_wr_data),
    .wrbuf_empty    (wrbuf_empty)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                               input logic rq, input logic [AW-1:0] lo, input logic [AW-1:0] hi,
                               input logic frz);
    enq_valid      = ev;
    enq_addr       = ea;
    enq_data       = ed;
    rd_req         = rq;
    rd_addr_lo     = lo;
    rd_addr_hi     = hi;
    lsu_freeze_dc3 = frz;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    tick();

    // Reset state
    checkOutput("rst_enq_ready", 64'(enq_ready), 64'd1);
    checkOutput("rst_wren", 64'(dccm_wren), 64'd0);
    checkOutput("rst_empty", 64'(wrbuf_empty), 64'd1);
    checkOutput("rst_conflict", 64'(rd_conflict), 64'd0);
    checkOutput("rst_wr_addr", 64'(dccm_wr_addr), 64'd0);
    checkOutput("rst_wr_data", 64'(dccm_wr_data), 64'd0);
    rst = 1'b0;
    tick();

    // Single store drains the cycle after it is accepted
    applyStimulus(1'b1, 16'h0100, 39'h5A, 1'b0, '0, '0, 1'b0);
    checkOutput("t1_no_bypass", 64'(dccm_wren), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    checkOutput("t1_wren", 64'(dccm_wren), 64'd1);
    checkOutput("t1_addr", 64'(dccm_wr_addr), 64'h100);
    checkOutput("t1_data", 64'(dccm_wr_data), 64'h5A);
    checkOutput("t1_not_empty", 64'(wrbuf_empty), 64'd0);
    tick();
    checkOutput("t1_empty_after", 64'(wrbuf_empty), 64'd1);
    checkOutput("t1_wren_after", 64'(dccm_wren), 64'd0);

    // Fill with reads holding the port, then full-buffer enqueue during a drain
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'(16'h0010 + 4 * i), 39'(8'h11 * (i + 1)), 1'b1, 16'h0F00, 16'h0F04, 1'b0);
      checkOutput("t2_fill_ready", 64'(enq_ready), 64'd1);
      checkOutput("t2_fill_wren", 64'(dccm_wren), 64'd0);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0F00, 16'h0F04, 1'b0);
    checkOutput("t2_full_ready", 64'(enq_ready), 64'd0);
    checkOutput("t2_full_wren", 64'(dccm_wren), 64'd0);
    checkOutput("t2_no_conflict", 64'(rd_conflict), 64'd0);
    applyStimulus(1'b1, 16'h099C, 39'h77, 1'b0, '0, '0, 1'b0);
    checkOutput("t5_ready_while_drain", 64'(enq_ready), 64'd0);
    checkOutput("t2_drain0_wren", 64'(dccm_wren), 64'd1);
    checkOutput("t2_drain0_addr", 64'(dccm_wr_addr), 64'h10);
    checkOutput("t2_drain0_data", 64'(dccm_wr_data), 64'h11);
    tick();
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
      checkOutput("t2_drain_ready", 64'(enq_ready), 64'd1);
      checkOutput("t2_drain_wren", 64'(dccm_wren), 64'd1);
      checkOutput("t2_drain_addr", 64'(dccm_wr_addr), 64'(16'h0010 + 4 * i));
      checkOutput("t2_drain_data", 64'(dccm_wr_data), 64'(8'h11 * (i + 1)));
      tick();
    end
    checkOutput("t5_rejected_enq_gone", 64'(wrbuf_empty), 64'd1);
    checkOutput("t5_no_extra_wren", 64'(dccm_wren), 64'd0);

    // Duplicate address entries held by freeze, then a word-aligned read against them
    applyStimulus(1'b1, 16'h0200, 39'h1111, 1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b1, 16'h0200, 39'h2222, 1'b0, '0, '0, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0202, 16'h0500, 1'b1);
`ifdef RV_DCCM_WRBUF_FWD_EN
    checkOutput("t3_hit_lo", 64'(fwd_hit_lo), 64'd1);
    checkOutput("t3_data_lo", 64'(fwd_data_lo), 64'h2222);
    checkOutput("t3_conflict", 64'(rd_conflict), 64'd0);
`else
    checkOutput("t3_hit_lo", 64'(fwd_hit_lo), 64'd0);
    checkOutput("t3_data_lo", 64'(fwd_data_lo), 64'd0);
    checkOutput("t3_conflict", 64'(rd_conflict), 64'd1);
`endif
    checkOutput("t3_hit_hi", 64'(fwd_hit_hi), 64'd0);
    checkOutput("t3_wren_frozen", 64'(dccm_wren), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, 16'h0202, 16'h0500, 1'b1);
    checkOutput("t3_unqualified_conflict", 64'(rd_conflict), 64'd0);
    checkOutput("t3_unqualified_hit", 64'(fwd_hit_lo), 64'd0);

    // Same-cycle enqueue matching the hi read address
    applyStimulus(1'b1, 16'h0300, 39'h3333, 1'b1, 16'h0500, 16'h0300, 1'b1);
    checkOutput("t4_conflict", 64'(rd_conflict), 64'd1);
    checkOutput("t4_hit_hi", 64'(fwd_hit_hi), 64'd0);
    checkOutput("t4_hit_lo", 64'(fwd_hit_lo), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0500, 16'h0301, 1'b1);
`ifdef RV_DCCM_WRBUF_FWD_EN
    checkOutput("t4_later_hit_hi", 64'(fwd_hit_hi), 64'd1);
    checkOutput("t4_later_data_hi", 64'(fwd_data_hi), 64'h3333);
    checkOutput("t4_later_conflict", 64'(rd_conflict), 64'd0);
`else
    checkOutput("t4_later_hit_hi", 64'(fwd_hit_hi), 64'd0);
    checkOutput("t4_later_conflict", 64'(rd_conflict), 64'd1);
`endif

    // Reset with three frozen entries pending
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    checkOutput("t6_pre_empty", 64'(wrbuf_empty), 64'd0);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_empty", 64'(wrbuf_empty), 64'd1);
    checkOutput("t6_rst_ready", 64'(enq_ready), 64'd1);
    checkOutput("t6_rst_wren", 64'(dccm_wren), 64'd0);
    checkOutput("t6_rst_wr_addr", 64'(dccm_wr_addr), 64'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t6_post_wren", 64'(dccm_wren), 64'd0);
      checkOutput("t6_post_empty", 64'(wrbuf_empty), 64'd1);
      tick();
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 16'h0200, 16'h0300, 1'b0);
    checkOutput("t6_post_conflict", 64'(rd_conflict), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
